// File: rtl/opb_reg_pkg.sv
// Shared types and constants for the OPB software-register slaves.
package opb_reg_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ACK  = 2'd1,
      GAP  = 2'd2
   } state_t;

   localparam int unsigned OPB_BYTE_LANES = 4;
   localparam int unsigned WORD_OFS_MSB   = 7;
   localparam int unsigned WORD_OFS_LSB   = 2;

   // Big-endian <-> little-endian bit order swap of a 32-bit word.
   function automatic logic [31:0] bit_rev32(input logic [31:0] x);
      logic [31:0] r;
      r = '0;
      for (int i = 0; i < 32; i++) begin
         r[i] = x[31-i];
      end
      return r;
   endfunction

endpackage

// File: rtl/opb_addr_decode.sv
// OPB slave window decode: hit anywhere in [C_BASEADDR, C_HIGHADDR], reg_hit at word offset 0.
module opb_addr_decode
   import opb_reg_pkg::*;
#(
   parameter int unsigned               C_OPB_AWIDTH = 32,
   parameter logic [C_OPB_AWIDTH-1:0]   C_BASEADDR   = '0,
   parameter logic [C_OPB_AWIDTH-1:0]   C_HIGHADDR   = C_OPB_AWIDTH'(32'h000000FF)
) (
   input  logic                    select,
   input  logic [C_OPB_AWIDTH-1:0] addr,
   output logic                    hit_c,
   output logic                    reg_hit_c
);

   localparam int unsigned AW = C_OPB_AWIDTH;

   logic          below_base;
   logic          above_high;
   logic [AW-1:0] unused_base_diff;
   logic [AW-1:0] unused_high_diff;

   // Unsigned window compare via borrow of a one-bit-wider subtraction.
   assign {below_base, unused_base_diff} = {1'b0, addr} - {1'b0, C_BASEADDR};
   assign {above_high, unused_high_diff} = {1'b0, C_HIGHADDR} - {1'b0, addr};

   assign hit_c     = select & ~below_base & ~above_high;
   assign reg_hit_c = hit_c & (addr[WORD_OFS_MSB:WORD_OFS_LSB] == '0);

endmodule

// File: rtl/opb_register_ppc2simulink.sv
// OPB slave register, PPC -> fabric. Define OPB_REG_PPC2SIM_READBACK_EN to return
// the stored word on reads at offset 0; otherwise reads are acked with zero data.
module opb_register_ppc2simulink
   import opb_reg_pkg::*;
#(
   parameter logic [31:0] C_BASEADDR   = 32'h00000000,
   parameter logic [31:0] C_HIGHADDR   = 32'h000000FF,
   parameter int unsigned C_OPB_AWIDTH = 32,
   parameter int unsigned C_OPB_DWIDTH = 32,
   parameter logic [31:0] C_INIT       = 32'h00000000
) (
   input  logic                    OPB_Clk,
   input  logic                    OPB_Rst_n,
   input  logic [0:C_OPB_AWIDTH-1] OPB_ABus,
   input  logic [0:3]              OPB_BE,
   input  logic [0:C_OPB_DWIDTH-1] OPB_DBus,
   input  logic                    OPB_RNW,
   input  logic                    OPB_select,
   input  logic                    OPB_seqAddr,
   output logic [0:C_OPB_DWIDTH-1] Sl_DBus,
   output logic                    Sl_errAck,
   output logic                    Sl_retry,
   output logic                    Sl_toutSup,
   output logic                    Sl_xferAck,
   output logic [31:0]             user_data_out,
   output logic                    user_data_valid
);

   localparam int unsigned DW = C_OPB_DWIDTH;

   state_t                  state, state_next;
   logic [C_OPB_AWIDTH-1:0] abus;
   logic [DW-1:0]           wdata;
   logic                    hit_c, reg_hit_c, decode_c;
   logic                    ack_q, ack_next;
   logic                    valid_q, valid_next;
   logic [DW-1:0]           data_q, data_next;
   logic                    unused_seq_addr;

   // Declaring internals [N-1:0] maps OPB bit 0 onto the MSB.
   assign abus            = OPB_ABus;
   assign wdata           = OPB_DBus;
   assign unused_seq_addr = OPB_seqAddr;

   opb_addr_decode #(
      .C_OPB_AWIDTH (C_OPB_AWIDTH),
      .C_BASEADDR   (C_OPB_AWIDTH'(C_BASEADDR)),
      .C_HIGHADDR   (C_OPB_AWIDTH'(C_HIGHADDR))
   ) u_decode (
      .select    (OPB_select),
      .addr      (abus),
      .hit_c     (hit_c),
      .reg_hit_c (reg_hit_c)
   );

`ifdef OPB_REG_PPC2SIM_READBACK_EN
   logic [DW-1:0] rdata_q, rdata_next;
`endif

   // Next state and next registered outputs.
   always_comb begin
      state_next = state;
      decode_c   = 1'b0;
      ack_next   = 1'b0;
      valid_next = 1'b0;
      data_next  = data_q;
`ifdef OPB_REG_PPC2SIM_READBACK_EN
      rdata_next = '0;
`endif
      // GAP is the dead cycle after an ack; a still-held select re-decodes there,
      // giving one ack every two cycles.
      unique case (state)
         IDLE, GAP: begin
            if (hit_c) begin
               state_next = ACK;
               decode_c   = 1'b1;
            end else begin
               state_next = IDLE;
            end
         end
         ACK:     state_next = GAP;
         default: state_next = IDLE;
      endcase

      ack_next = decode_c;
      if (decode_c && reg_hit_c && !OPB_RNW) begin
         valid_next = 1'b1;
         for (int unsigned i = 0; i < OPB_BYTE_LANES; i++) begin
            if (OPB_BE[2'(i)]) begin
               data_next[5'(8*(OPB_BYTE_LANES-1-i)) +: 8] = wdata[5'(8*(OPB_BYTE_LANES-1-i)) +: 8];
            end
         end
      end
`ifdef OPB_REG_PPC2SIM_READBACK_EN
      if (decode_c && reg_hit_c && OPB_RNW) begin
         rdata_next = data_q;
      end
`endif
   end

   always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
      if (!OPB_Rst_n) begin
         state   <= IDLE;
         ack_q   <= 1'b0;
         valid_q <= 1'b0;
         data_q  <= DW'(C_INIT);
`ifdef OPB_REG_PPC2SIM_READBACK_EN
         rdata_q <= '0;
`endif
      end else begin
         state   <= state_next;
         ack_q   <= ack_next;
         valid_q <= valid_next;
         data_q  <= data_next;
`ifdef OPB_REG_PPC2SIM_READBACK_EN
         rdata_q <= rdata_next;
`endif
      end
   end

`ifdef OPB_REG_PPC2SIM_READBACK_EN
   assign Sl_DBus = rdata_q;
`else
   assign Sl_DBus = '0;
`endif

   assign Sl_xferAck      = ack_q;
   assign Sl_errAck       = 1'b0;
   assign Sl_retry        = 1'b0;
   assign Sl_toutSup      = 1'b0;
   assign user_data_out   = 32'(data_q);
   assign user_data_valid = valid_q;

endmodule
